// File: rtl/fog_err_demod.sv
// Square-wave bias modulation generator and synchronous error demodulator for the closed-loop gyro.
// Integrates ADC samples over each half-period and emits the high-minus-low difference once per period.
module fog_err_demod #(
  parameter int ADC_W = 14,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [ADC_W-1:0] i_adc,
  input  logic                    i_adc_vld,
  input  logic        [CNT_W-1:0] i_freq,
  input  logic        [CNT_W-1:0] i_ignore,
  input  logic                    i_polarity,
  output logic                    o_mod,
  output logic signed [ACC_W-1:0] o_err,
  output logic                    o_trig,
  output logic        [1:0]       o_state
);

  // Accumulator headroom: a full half-period of full-scale samples plus the final difference must fit.
  if (ADC_W + CNT_W + 1 >= ACC_W) begin : g_width_check
    $error("fog_err_demod: ACC_W too small for ADC_W + CNT_W + 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } state_t;

  state_t                    state;
  logic        [CNT_W-1:0]   cnt;
  logic        [CNT_W-1:0]   freq_l;
  logic        [CNT_W-1:0]   ign_l;
  logic                      pol_l;
  logic signed [ACC_W-1:0]   acc_h;
  logic signed [ACC_W-1:0]   acc_l;

  logic                      cfg_ok;
  logic                      last_clk;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   add_val;
  logic signed [ACC_W-1:0]   acc_l_fin;
  logic signed [ACC_W-1:0]   diff;

  assign cfg_ok     = (i_freq >= CNT_W'(2)) && (i_ignore < i_freq);
  assign last_clk   = (cnt == freq_l - CNT_W'(1));
  assign sample_ext = {{(ACC_W-ADC_W){i_adc[ADC_W-1]}}, i_adc};
  assign add_val    = (i_adc_vld && (cnt >= ign_l)) ? sample_ext : '0;
  // The last NEG clock's sample is folded in combinationally so the result leaves on the same edge.
  assign acc_l_fin  = acc_l + add_val;
  assign diff       = pol_l ? (acc_l_fin - acc_h) : (acc_h - acc_l_fin);
  assign o_state    = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      freq_l <= '0;
      ign_l  <= '0;
      pol_l  <= 1'b0;
      acc_h  <= '0;
      acc_l  <= '0;
      o_mod  <= 1'b0;
      o_err  <= '0;
      o_trig <= 1'b0;
    end else begin
      o_trig <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          acc_h <= '0;
          acc_l <= '0;
          if (i_en && cfg_ok) begin
            state  <= POS;
            o_mod  <= 1'b1;
            freq_l <= i_freq;
            ign_l  <= i_ignore;
            pol_l  <= i_polarity;
          end else begin
            o_mod <= 1'b0;
          end
        end

        POS: begin
          if (!i_en) begin
            state <= IDLE;
            o_mod <= 1'b0;
            cnt   <= '0;
            acc_h <= '0;
            acc_l <= '0;
          end else begin
            acc_h <= acc_h + add_val;
            if (last_clk) begin
              cnt   <= '0;
              state <= NEG;
              o_mod <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        NEG: begin
          if (!i_en) begin
            state <= IDLE;
            o_mod <= 1'b0;
            cnt   <= '0;
            acc_h <= '0;
            acc_l <= '0;
          end else if (last_clk) begin
            o_err  <= diff;
            o_trig <= 1'b1;
            cnt    <= '0;
            acc_h  <= '0;
            acc_l  <= '0;
            if (cfg_ok) begin
              state  <= POS;
              o_mod  <= 1'b1;
              freq_l <= i_freq;
              ign_l  <= i_ignore;
              pol_l  <= i_polarity;
            end else begin
              state <= IDLE;
              o_mod <= 1'b0;
            end
          end else begin
            acc_l <= acc_l_fin;
            cnt   <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          o_mod <= 1'b0;
          cnt   <= '0;
          acc_h <= '0;
          acc_l <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fog_err_demod.sv
// Bench for fog_err_demod: table of full-period vectors plus hand sequences for config latching,
// invalid config, and mid-period abort/reset. Expected errors are queued and popped on o_trig.
module tb_fog_err_demod;
  localparam int ADC_W = 14;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;

  typedef struct {
    string  name;
    int     freq;
    int     ign;
    bit     pol;
    int     adc_p;
    int     adc_n;
    bit     gap;
    int     periods;
    longint err;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic signed [ADC_W-1:0] adc = '0;
  logic                    adc_vld = 1'b0;
  logic        [CNT_W-1:0] freq;
  logic        [CNT_W-1:0] ignore;
  logic                    pol;
  logic                    o_mod;
  logic signed [ACC_W-1:0] o_err;
  logic                    o_trig;
  logic        [1:0]       o_state;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     trig_count = 0;
  longint exp_q[$];
  int     trig_cyc[$];
  int     adc_p = 0;
  int     adc_n = 0;
  bit     gap = 1'b0;
  bit     tog = 1'b0;
  vec_t   vecs[8];

  fog_err_demod #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_adc(adc), .i_adc_vld(adc_vld),
    .i_freq(freq), .i_ignore(ignore), .i_polarity(pol),
    .o_mod(o_mod), .o_err(o_err), .o_trig(o_trig), .o_state(o_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ADC source follows the modulation phase; gapped mode asserts valid every other clock.
  always @(negedge clk) begin
    tog = ~tog;
    adc = o_mod ? adc_p[ADC_W-1:0] : adc_n[ADC_W-1:0];
    adc_vld = gap ? tog : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && o_trig) begin
      trig_count++;
      trig_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_trig: o_trig got 1, required 0 (cycle %0d)", cyc);
      end else begin
        checkOutput("o_err", longint'(o_err), exp_q.pop_front());
      end
    end
  end

  task automatic waitTrigs(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (trig_count >= target) return;
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s_timeout: triggers got %0d, required %0d", name, trig_count, target);
  endtask

  task automatic waitMod(input logic val, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (o_mod === val) return;
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s_timeout: o_mod got %0b, required %0b", name, o_mod, val);
  endtask

  task automatic applyStimulus(input vec_t v);
    int base;
    int c0;
    en = 1'b0;
    @(negedge clk);
    #1;
    freq   = CNT_W'(v.freq);
    ignore = CNT_W'(v.ign);
    pol    = v.pol;
    adc_p  = v.adc_p;
    adc_n  = v.adc_n;
    gap    = v.gap;
    trig_cyc.delete();
    base = trig_count;
    c0   = cyc;
    for (int k = 0; k < v.periods; k++) exp_q.push_back(v.err);
    en = 1'b1;
    waitTrigs(base + v.periods, 2 * v.freq * v.periods + 20, v.name);
    en = 1'b0;
    for (int k = 0; k < v.periods && k < trig_cyc.size(); k++)
      checkOutput({v.name, "_trig_time"}, trig_cyc[k] - c0, 1 + 2 * v.freq * (k + 1));
  endtask

  initial begin
    int base;
    int c0;
    vecs[0] = '{"flat",      4, 1, 1'b0,   100,   100, 1'b0, 2, 0};
    vecs[1] = '{"sq_pol0",   4, 1, 1'b0,   200,  -200, 1'b0, 2, 1200};
    vecs[2] = '{"sq_pol1",   4, 1, 1'b1,   200,  -200, 1'b0, 2, -1200};
    vecs[3] = '{"freq_min",  2, 0, 1'b0,    -5,     7, 1'b0, 2, -24};
    vecs[4] = '{"ign_max",   5, 4, 1'b0,  1000, -1000, 1'b0, 2, 2000};
    vecs[5] = '{"gapped",    4, 0, 1'b0,    10,     0, 1'b1, 2, 20};
    vecs[6] = '{"big",   20000, 0, 1'b0,  8191, -8192, 1'b0, 1, 327660000};
    vecs[7] = '{"neg_full",  7, 3, 1'b1, -8192,  8191, 1'b0, 2, 65532};

    rst = 1'b1; en = 1'b0; freq = 16'd4; ignore = 16'd1; pol = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_err", longint'(o_err), 0);
    checkOutput("rst_trig", longint'(o_trig), 0);
    checkOutput("rst_mod", longint'(o_mod), 0);
    checkOutput("rst_state", longint'(o_state), 0);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Config changed mid-POS only applies from the next period.
    en = 1'b0;
    @(negedge clk);
    #1;
    freq = 16'd4; ignore = 16'd1; pol = 1'b0; adc_p = 200; adc_n = -200; gap = 1'b0;
    trig_cyc.delete();
    base = trig_count;
    c0 = cyc;
    exp_q.push_back(1200); exp_q.push_back(2400); exp_q.push_back(2400);
    en = 1'b1;
    waitMod(1'b1, 10, "t4_pos");
    freq = 16'd6; ignore = 16'd0;
    waitTrigs(base + 3, 60, "t4");
    en = 1'b0;
    if (trig_cyc.size() >= 3) begin
      checkOutput("t4_first", trig_cyc[0] - c0, 9);
      checkOutput("t4_second", trig_cyc[1] - trig_cyc[0], 12);
      checkOutput("t4_third", trig_cyc[2] - trig_cyc[1], 12);
    end

    // Invalid configurations hold IDLE; a valid one starts POS on the next edge.
    @(negedge clk);
    #1;
    freq = 16'd1; ignore = 16'd0; adc_p = 100; adc_n = 100;
    en = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t5_f1_mod", longint'(o_mod), 0);
    checkOutput("t5_f1_state", longint'(o_state), 0);
    freq = 16'd5; ignore = 16'd5;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("t5_ign_mod", longint'(o_mod), 0);
    checkOutput("t5_ign_state", longint'(o_state), 0);
    freq = 16'd4; ignore = 16'd1;
    base = trig_count;
    exp_q.push_back(0);
    @(negedge clk);
    #1;
    checkOutput("t5_restart_mod", longint'(o_mod), 1);
    waitTrigs(base + 1, 20, "t5");
    en = 1'b0;

    // Abort mid-NEG by enable, then by reset.
    @(negedge clk);
    #1;
    adc_p = 200; adc_n = -200;
    base = trig_count;
    exp_q.push_back(1200);
    en = 1'b1;
    waitTrigs(base + 1, 20, "t6_a");
    waitMod(1'b0, 10, "t6_neg");
    en = 1'b0;
    adc_p = 50; adc_n = -50;
    @(negedge clk);
    #1;
    checkOutput("t6_abort_mod", longint'(o_mod), 0);
    checkOutput("t6_abort_state", longint'(o_state), 0);
    checkOutput("t6_hold_err", longint'(o_err), 1200);
    base = trig_count;
    exp_q.push_back(300);
    en = 1'b1;
    waitTrigs(base + 1, 20, "t6_b");
    waitMod(1'b0, 10, "t6_neg2");
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t6_rst_err", longint'(o_err), 0);
    checkOutput("t6_rst_trig", longint'(o_trig), 0);
    checkOutput("t6_rst_mod", longint'(o_mod), 0);
    checkOutput("t6_rst_state", longint'(o_state), 0);
    base = trig_count;
    exp_q.push_back(300);
    rst = 1'b0;
    waitTrigs(base + 1, 20, "t6_c");
    en = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    checkOutput("queue_empty", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
